// File: rtl/psimd_rf_pkg.sv
// Shared constants, sizing helpers and word/mask types for the PSIMD vector register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only). Optional feature macro used by the top: PSIMD_RF_BYPASS_EN.
package psimd_rf_pkg;

   localparam int DEF_REG_WIDTH = 64;
   localparam int DEF_LANE_W    = 16;
   localparam int DEF_NUM_REGS  = 32;
   localparam int DEF_NUM_RD    = 3;

   // Address width needed to select one of num_regs registers.
   function automatic int rf_addr_w(input int num_regs);
      return $clog2(num_regs);
   endfunction

   // Number of independently maskable lanes in one register word.
   function automatic int rf_lanes(input int reg_width, input int lane_w);
      return reg_width / lane_w;
   endfunction

   localparam int DEF_LANES = rf_lanes(DEF_REG_WIDTH, DEF_LANE_W);

   typedef logic [DEF_LANES-1:0]     lane_mask_t;
   typedef logic [DEF_REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/psimd_rf_scoreboard.sv
// Busy scoreboard: tracks registers awaiting writeback and flags WAW / spurious-writeback hazards.
// Latency: busy set/clear and error flags visible 1 cycle after the edge; rd_busy is combinational from flops.
// Backpressure: none; issue and writeback are always accepted, error flags are diagnostic only.
module psimd_rf_scoreboard
   import psimd_rf_pkg::*;
#(
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int NUM_RD   = DEF_NUM_RD,
   localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     iss_pair,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     wr_pair,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic                     waw_err,
   output logic                     wb_err
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                waw_err_q, waw_err_d;
   logic                wb_err_q, wb_err_d;
   logic [ADDR_W-1:0]   iss_addr1;
   logic [ADDR_W-1:0]   wr_addr1;

   // Second half of a pair; NUM_REGS is a power of two so the add wraps naturally.
   assign iss_addr1 = iss_addr + ADDR_W'(1);
   assign wr_addr1  = wr_addr + ADDR_W'(1);

   // Next busy state: clear writeback targets first so a same-cycle issue (newer producer) wins.
   always_comb begin
      busy_d    = busy_q;
      waw_err_d = iss_en && (busy_q[iss_addr] || (iss_pair && busy_q[iss_addr1]));
      wb_err_d  = wr_en && (!busy_q[wr_addr] || (wr_pair && !busy_q[wr_addr1]));
      if (wr_en) begin
         busy_d[wr_addr] = 1'b0;
         if (wr_pair) busy_d[wr_addr1] = 1'b0;
      end
      if (iss_en) begin
         busy_d[iss_addr] = 1'b1;
         if (iss_pair) busy_d[iss_addr1] = 1'b1;
      end
   end

   // Scoreboard and error-pulse flops; reset drops every outstanding busy mark.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q    <= '0;
         waw_err_q <= 1'b0;
         wb_err_q  <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         waw_err_q <= waw_err_d;
         wb_err_q  <= wb_err_d;
      end
   end

   // Busy lookup per read port, straight from the flops (never bypassed).
   always_comb begin
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
      end
   end

   assign waw_err = waw_err_q;
   assign wb_err  = wb_err_q;

endmodule

// File: rtl/psimd_vreg_file.sv
// PSIMD vector register file: NUM_RD combinational reads, one lane-masked paired write, busy scoreboard.
// Latency: reads 0 cycles; writes visible next cycle (same cycle when built with PSIMD_RF_BYPASS_EN).
// Backpressure: none; every write/issue is accepted, hazards are only reported via waw_err/wb_err.
module psimd_vreg_file
   import psimd_rf_pkg::*;
#(
   parameter  int REG_WIDTH = DEF_REG_WIDTH,
   parameter  int NUM_REGS  = DEF_NUM_REGS,
   parameter  int NUM_RD    = DEF_NUM_RD,
   parameter  int LANE_W    = DEF_LANE_W,
   localparam int ADDR_W    = rf_addr_w(NUM_REGS),
   localparam int LANES     = rf_lanes(REG_WIDTH, LANE_W)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
   output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]           rd_busy,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic                        wr_pair,
   input  logic [REG_WIDTH-1:0]        wr_data0,
   input  logic [REG_WIDTH-1:0]        wr_data1,
   input  logic [LANES-1:0]            wr_lane_mask,
   input  logic                        iss_en,
   input  logic [ADDR_W-1:0]           iss_addr,
   input  logic                        iss_pair,
   output logic                        waw_err,
   output logic                        wb_err
);

   logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
   logic [REG_WIDTH-1:0] regs_d [NUM_REGS];
   logic [ADDR_W-1:0]    wr_addr1;
   logic [REG_WIDTH-1:0] wr_word0;
   logic [REG_WIDTH-1:0] wr_word1;
   logic [ADDR_W-1:0]    rd_idx [NUM_RD];

   assign wr_addr1 = wr_addr + ADDR_W'(1);

   // Post-write words for both pair halves: masked lanes from wr_data, the rest from storage.
   // Shared by the storage update and the optional read bypass.
   always_comb begin
      wr_word0 = regs_q[wr_addr];
      wr_word1 = regs_q[wr_addr1];
      for (int i = 0; i < LANES; i++) begin
         if (wr_lane_mask[i]) begin
            wr_word0[i*LANE_W +: LANE_W] = wr_data0[i*LANE_W +: LANE_W];
            wr_word1[i*LANE_W +: LANE_W] = wr_data1[i*LANE_W +: LANE_W];
         end
      end
   end

   // Next storage contents; an all-zero mask rewrites the old value, i.e. no change.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_word0;
         if (wr_pair) regs_d[wr_addr1] = wr_word1;
      end
   end

   // Register storage with synchronous clear that overrides any concurrent write.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (!rst_n) regs_q[r] <= '0;
         else        regs_q[r] <= regs_d[r];
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign rd_idx[k] = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef PSIMD_RF_BYPASS_EN
      // Forward the in-flight write (either pair half) so the reader sees the post-write value now.
      assign rd_data[k*REG_WIDTH +: REG_WIDTH] =
         (wr_en && (rd_idx[k] == wr_addr))               ? wr_word0 :
         (wr_en && wr_pair && (rd_idx[k] == wr_addr1))   ? wr_word1 :
                                                           regs_q[rd_idx[k]];
`else
      assign rd_data[k*REG_WIDTH +: REG_WIDTH] = regs_q[rd_idx[k]];
`endif
   end

   psimd_rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_pair (iss_pair),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_pair  (wr_pair),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy),
      .waw_err  (waw_err),
      .wb_err   (wb_err)
   );

endmodule
